// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared tank types, keycodes and map geometry
package tank_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } move_state_t;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;

    localparam int TILE_PX = 32;
    localparam int MAP_W   = 20;
    localparam int MAP_H   = 15;

    // Bottom-left player starts facing up, top-right player facing down.
    function automatic dir_t home_dir(input logic player);
        return player ? UP : DOWN;
    endfunction

endpackage

// File: rtl/tank_key_decode.sv
// rtl/tank_key_decode.sv - per-player keycode to direction decode
module tank_key_decode
    import tank_pkg::*;
(
    input  logic       player,
    input  logic [7:0] keycode,
    output logic       key_hit,
    output dir_t       key_dir
);

    always_comb begin
        key_hit = 1'b1;
        key_dir = UP;
        if (player) begin
            case (keycode)
                KEY_W:   key_dir = UP;
                KEY_S:   key_dir = DOWN;
                KEY_A:   key_dir = LEFT;
                KEY_D:   key_dir = RIGHT;
                default: key_hit = 1'b0;
            endcase
        end else begin
            case (keycode)
                KEY_UP:    key_dir = UP;
                KEY_DOWN:  key_dir = DOWN;
                KEY_LEFT:  key_dir = LEFT;
                KEY_RIGHT: key_dir = RIGHT;
                default:   key_hit = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/tank_move_ctrl.sv
// rtl/tank_move_ctrl.sv - key to move-request auto-repeat FSM; TANK_MOVE_DEBOUNCE_EN adds 2-frame press debounce
module tank_move_ctrl
    import tank_pkg::*;
#(
    parameter int INIT_DELAY    = 12,
    parameter int REPEAT_PERIOD = 6
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       player,
    input  logic [7:0] keycode,
    input  logic       move_ready,
    output logic       move_valid,
    output dir_t       move_dir,
    output dir_t       facing
);

    localparam int CNT_MAX = (INIT_DELAY > REPEAT_PERIOD) ? INIT_DELAY : REPEAT_PERIOD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INIT_LD = CW'(INIT_DELAY);
    localparam logic [CW-1:0] REP_LD  = CW'(REPEAT_PERIOD);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          key_hit;
    dir_t          key_dir;
    dir_t          last_dir;
    move_state_t   state;
    logic [CW-1:0] counter;
    logic          press_ok;
    logic          new_press;
    logic          stall;

    tank_key_decode u_decode (
        .player  (player),
        .keycode (keycode),
        .key_hit (key_hit),
        .key_dir (key_dir)
    );

`ifdef TANK_MOVE_DEBOUNCE_EN
    logic prev_hit;
    dir_t prev_dir;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            prev_hit <= 1'b0;
            prev_dir <= UP;
        end else begin
            prev_hit <= key_hit;
            prev_dir <= key_dir;
        end
    end

    assign press_ok = key_hit && prev_hit && (prev_dir == key_dir);
`else
    assign press_ok = key_hit;
`endif

    assign new_press = press_ok && ((state == IDLE) || (key_dir != last_dir));
    // A stalled request freezes everything so only one move is ever outstanding.
    assign stall     = move_valid && !move_ready;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            move_valid <= 1'b0;
            state      <= IDLE;
            counter    <= '0;
            last_dir   <= home_dir(player);
            move_dir   <= home_dir(player);
            facing     <= home_dir(player);
        end else if (!stall) begin
            if (move_valid) move_valid <= 1'b0;
            if (state == IDLE) begin
                if (new_press) begin
                    move_valid <= 1'b1;
                    move_dir   <= key_dir;
                    facing     <= key_dir;
                    last_dir   <= key_dir;
                    counter    <= INIT_LD;
                    state      <= DELAY;
                end
            end else if (!key_hit) begin
                state   <= IDLE;
                counter <= '0;
            end else if (new_press) begin
                move_valid <= 1'b1;
                move_dir   <= key_dir;
                facing     <= key_dir;
                last_dir   <= key_dir;
                counter    <= INIT_LD;
                state      <= DELAY;
            end else if ((key_dir == last_dir) && (counter == CNT_ONE)) begin
                move_valid <= 1'b1;
                move_dir   <= key_dir;
                facing     <= key_dir;
                counter    <= REP_LD;
                state      <= REPEAT;
            end else if (counter > CNT_ONE) begin
                counter <= counter - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_tank_move_ctrl.sv
// tb/tb_tank_move_ctrl.sv - scoreboard bench for tank_move_ctrl
module tb_tank_move_ctrl;
    import tank_pkg::*;

`ifdef TANK_MOVE_DEBOUNCE_EN
    localparam int D = 1;
`else
    localparam int D = 0;
`endif

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       player = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic       move_ready = 1'b1;
    logic       move_valid;
    dir_t       move_dir;
    dir_t       facing;

    always #5 frame_clk = ~frame_clk;

    tank_move_ctrl #(.INIT_DELAY(12), .REPEAT_PERIOD(6)) dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .player     (player),
        .keycode    (keycode),
        .move_ready (move_ready),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .facing     (facing)
    );

    typedef struct {
        int   frame;
        dir_t dir;
    } exp_t;

    exp_t sb[$];
    int   frame;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_move(input int f, input dir_t d);
        exp_t e;
        e.frame = f;
        e.dir   = d;
        sb.push_back(e);
    endtask

    task automatic do_reset(input logic p);
        player     = p;
        Reset      = 1'b1;
        keycode    = 8'h00;
        move_ready = 1'b1;
        sb.delete();
        @(posedge frame_clk);
        #1;
        Reset = 1'b0;
        check("rst_valid", int'(move_valid), 0);
        check("rst_dir", int'(move_dir), int'(p ? UP : DOWN));
        check("rst_facing", int'(facing), int'(p ? UP : DOWN));
        frame = 0;
    endtask

    task automatic step(input logic [7:0] k, input logic rdy, input logic rst);
        logic exp_v;
        keycode    = k;
        move_ready = rdy;
        Reset      = rst;
        @(negedge frame_clk);
        exp_v = (sb.size() > 0) && (sb[0].frame == frame);
        check($sformatf("valid_f%0d", frame), int'(move_valid), int'(exp_v));
        if (exp_v) begin
            check($sformatf("dir_f%0d", frame), int'(move_dir), int'(sb[0].dir));
            check($sformatf("facing_f%0d", frame), int'(facing), int'(sb[0].dir));
            void'(sb.pop_front());
        end
        @(posedge frame_clk);
        #1;
        Reset = 1'b0;
        frame++;
    endtask

    task automatic hold(input logic [7:0] k, input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(k, rdy, 1'b0);
    endtask

    initial begin
        // Held W key: first move, then INIT_DELAY, then REPEAT_PERIOD spacing.
        do_reset(1'b1);
        expect_move(1 + D, UP);
        expect_move(13 + D, UP);
        expect_move(19 + D, UP);
        expect_move(25 + D, UP);
        if (D == 0) expect_move(31, UP);
        hold(KEY_W, 1'b1, 31);
        hold(8'h00, 1'b1, 2);
        check("sb_empty_s1", sb.size(), 0);

        // Other player's key ignored; arrow LEFT for one frame.
        do_reset(1'b0);
        if (D == 0) expect_move(6, LEFT);
        hold(KEY_W, 1'b1, 5);
        hold(KEY_LEFT, 1'b1, 1);
        hold(8'h00, 1'b1, 5);
        check("sb_empty_s2", sb.size(), 0);

        // Direction change restarts the initial delay.
        do_reset(1'b1);
        expect_move(1 + D, RIGHT);
        expect_move(6 + D, LEFT);
        expect_move(18 + D, LEFT);
        hold(KEY_D, 1'b1, 5);
        hold(KEY_A, 1'b1, 16);
        hold(8'h00, 1'b1, 2);
        check("sb_empty_s3", sb.size(), 0);
        check("s3_facing", int'(facing), int'(LEFT));

        // Backpressure holds the move and freezes the counter.
        do_reset(1'b1);
        for (int f = 1 + D; f <= 5; f++) expect_move(f, DOWN);
        expect_move(17, DOWN);
        hold(KEY_S, 1'b0, 5);
        hold(KEY_S, 1'b1, 16);
        check("sb_empty_s4", sb.size(), 0);

        // Release while stalled: exactly one transfer, then idle.
        do_reset(1'b1);
        for (int f = 1 + D; f <= 4; f++) expect_move(f, DOWN);
        hold(KEY_S, 1'b0, 2);
        hold(8'h00, 1'b0, 2);
        hold(8'h00, 1'b1, 17);
        check("sb_empty_s5", sb.size(), 0);

        // Reset during REPEAT discards state; held key issues again afterwards.
        do_reset(1'b0);
        expect_move(1 + D, LEFT);
        expect_move(13 + D, LEFT);
        expect_move(19 + D, LEFT);
        hold(KEY_LEFT, 1'b1, 22);
        step(KEY_LEFT, 1'b1, 1'b1);
        check("mid_rst_valid", int'(move_valid), 0);
        check("mid_rst_facing", int'(facing), int'(DOWN));
        expect_move(24 + D, LEFT);
        hold(KEY_LEFT, 1'b1, 8);
        check("sb_empty_s6", sb.size(), 0);

`ifdef TANK_MOVE_DEBOUNCE_EN
        // Single-frame glitch must not produce a move.
        do_reset(1'b1);
        hold(KEY_A, 1'b1, 1);
        hold(8'h00, 1'b1, 10);
        check("sb_empty_s7", sb.size(), 0);
        check("s7_facing", int'(facing), int'(UP));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
